issue_queue_2pusher: RTL and testbench
======================================

ISSUE_QUEUE_2PUSHER -- requirements
Module: issue_queue_2pusher

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload bit width.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; legal values are powers of two, >= 2.
REQ-003 SHALL have port sys_clk  input  1  single clock; all state rising-edge.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in0_valid  input  1  lane-0 (older) enqueue request.
REQ-006 SHALL have port in0_data  input  WIDTH  lane-0 payload.
REQ-007 SHALL have port in0_ready  output  1  lane-0 accept permission.
REQ-008 SHALL have port in1_valid  input  1  lane-1 (younger) enqueue request.
REQ-009 SHALL have port in1_data  input  WIDTH  lane-1 payload.
REQ-010 SHALL have port in1_ready  output  1  lane-1 accept permission.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_data  output  WIDTH  head entry payload.
REQ-013 SHALL have port out_ready  input  1  consumer accepts head.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 SHALL store entries in a circular buffer with read pointer, write pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-016 SHALL drive in0_ready = (count < DEPTH), from registered state only.
REQ-017 SHALL drive in1_ready = in0_valid & (count <= DEPTH-2), with no dependence on out_ready.
REQ-018 SHALL define in0_fire = in0_valid & in0_ready and in1_fire = in1_valid & in1_ready & in0_fire; lane 1 alone never enqueues.
REQ-019 SHALL, on in0_fire only, write in0_data at the write pointer and advance it by 1.
REQ-020 SHALL, on both fires, write in0_data at the write pointer, in1_data at write pointer+1 (wrapped), and advance by 2; in0_data is always older.
REQ-021 SHALL drive out_valid = (count != 0) and out_data = entry at read pointer, both from registered state.
REQ-022 SHALL, on out_valid & out_ready, advance the read pointer by 1.
REQ-023 SHALL update count by +in0_fire +in1_fire -pop in the same cycle; push and pop in one cycle both take effect.
REQ-024 SHALL have one-cycle latency: a write becomes visible at out_data no earlier than the next cycle; no combinational in->out path.
REQ-025 SHALL not bypass on full: when count = DEPTH, in0_ready = 0 even if out_ready = 1 that cycle.
REQ-026 SHALL ignore in*_data whenever the matching fire is low, and leave storage untouched.
REQ-027 SHALL ignore out_ready while out_valid = 0 (no underflow; count never wraps below 0 or above DEPTH).
REQ-028 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.

Reset
REQ-029 SHALL, while sys_rst_n = 0, asynchronously clear read pointer, write pointer and count to 0, forcing out_valid = 0, count = 0, in0_ready = 1, in1_ready = in0_valid.
REQ-030 SHALL discard all queued entries when reset asserts mid-operation; storage contents need not be cleared, out_data is don't-care while out_valid = 0.
REQ-031 SHALL resume normal operation on the first rising sys_clk after sys_rst_n deasserts.

Verification
REQ-032 SHALL cover dual push to full: cycle 1 in0=0x11,in1=0x22; cycle 2 in0=0x33,in1=0x44, out_ready=0 -> count=4, in0_ready=0, in1_ready=0, out_data=0x11.
REQ-033 SHALL cover drain order: from REQ-032 state, out_ready=1 for 4 cycles -> out_data 0x11,0x22,0x33,0x44, then out_valid=0, count=0.
REQ-034 SHALL cover lane gating: in0_valid=0, in1_valid=1, in1_data=0x55 -> nothing enqueued, count unchanged; with count=3, in0 and in1 valid -> only in0 accepted, in1_ready=0, count=4.
REQ-035 SHALL cover push+pop same cycle at count=2: dual push 0x66,0x77 with out_ready=1 -> count=3, head advances one entry, 0x66 then 0x77 follow prior entries.
REQ-036 SHALL cover pointer wrap: sustain single push and pop for 3*DEPTH cycles with incrementing data 0x01.. -> output sequence matches input exactly, count constant.
REQ-037 SHALL cover reset mid-operation: count=3, assert sys_rst_n=0 between clock edges -> out_valid=0 and count=0 immediately, first post-reset push 0x99 is the next out_data.

Source files
------------

// File: rtl/issue_queue_2pusher_if.sv
// Handshake bundle for the two-lane issue queue: two enqueue lanes, one dequeue port, occupancy.
interface issue_queue_2pusher_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                       in0_valid;
    logic [WIDTH-1:0]           in0_data;
    logic                       in0_ready;
    logic                       in1_valid;
    logic [WIDTH-1:0]           in1_data;
    logic                       in1_ready;
    logic                       out_valid;
    logic [WIDTH-1:0]           out_data;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, count
    );

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/issue_queue_2pusher.sv
// Circular-buffer issue queue accepting up to two in-order entries per cycle, popping one.
// Lane 0 is always the older entry; lane 1 only rides along with a lane-0 push.
module issue_queue_2pusher #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    issue_queue_2pusher_if.slave  iq
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic             w_in0_fire;
    logic             w_in1_fire;
    logic             w_pop;
    logic [PW-1:0]    w_wr_ptr_p1;
    logic [CW-1:0]    w_count_nxt;

    // Ready terms look only at registered occupancy, so a pop never frees a slot the same cycle.
    assign iq.in0_ready = (r_count < CW'(DEPTH));
    assign iq.in1_ready = iq.in0_valid & (r_count <= CW'(DEPTH-2));
    assign iq.out_valid = (r_count != '0);
    assign iq.out_data  = r_mem[r_rd_ptr];
    assign iq.count     = r_count;

    assign w_in0_fire  = iq.in0_valid & iq.in0_ready;
    assign w_in1_fire  = iq.in1_valid & iq.in1_ready & w_in0_fire;
    assign w_pop       = iq.out_valid & iq.out_ready;
    assign w_wr_ptr_p1 = r_wr_ptr + PW'(1);
    assign w_count_nxt = r_count + CW'(w_in0_fire) + CW'(w_in1_fire) - CW'(w_pop);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_in1_fire)
                r_wr_ptr <= r_wr_ptr + PW'(2);
            else if (w_in0_fire)
                r_wr_ptr <= w_wr_ptr_p1;
            r_count <= w_count_nxt;
        end
    end

    // Storage is data only: left out of reset, written solely on a matching fire.
    always_ff @(posedge sys_clk) begin
        if (w_in0_fire)
            r_mem[r_wr_ptr] <= iq.in0_data;
        if (w_in1_fire)
            r_mem[w_wr_ptr_p1] <= iq.in1_data;
    end
endmodule

// File: tb/tb_issue_queue_2pusher.sv
// Self-checking bench for issue_queue_2pusher: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_issue_queue_2pusher;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic sys_clk;
    logic sys_rst_n;

    issue_queue_2pusher_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) iq ();

    issue_queue_2pusher #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .iq        (iq)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] model_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Observable state depends only on how many entries the model holds and which is oldest.
    task automatic check_state(input string tag);
        int cnt;
        cnt = model_q.size();
        check_eq({tag, ".count"},     32'(iq.count), 32'(cnt));
        check_eq({tag, ".out_valid"}, 32'(iq.out_valid), 32'(cnt != 0));
        check_eq({tag, ".in0_ready"}, 32'(iq.in0_ready), 32'(cnt < DEPTH));
        check_eq({tag, ".in1_ready"}, 32'(iq.in1_ready), 32'(iq.in0_valid && (cnt <= DEPTH-2)));
        if (cnt != 0)
            check_eq({tag, ".out_data"}, 32'(iq.out_data), 32'(model_q[0]));
    endtask

    // One clock: drive at the falling edge, check, then apply the model's rules at the rising edge.
    task automatic cycle(input string tag, input logic v0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic [WIDTH-1:0] d1, input logic ordy);
        int cnt;
        bit f0, f1, pop;
        iq.in0_valid = v0;
        iq.in0_data  = d0;
        iq.in1_valid = v1;
        iq.in1_data  = d1;
        iq.out_ready = ordy;
        #1;
        check_state(tag);
        cnt = model_q.size();
        f0  = v0 && (cnt < DEPTH);
        f1  = f0 && v1 && (cnt <= DEPTH-2);
        pop = ordy && (cnt != 0);
        @(posedge sys_clk);
        if (pop) void'(model_q.pop_front());
        if (f0) model_q.push_back(d0);
        if (f1) model_q.push_back(d1);
        @(negedge sys_clk);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        sys_rst_n    = 1'b0;
        iq.in0_valid = 1'b0;
        iq.in0_data  = '0;
        iq.in1_valid = 1'b0;
        iq.in1_data  = '0;
        iq.out_ready = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
        check_eq("rst.count",     32'(iq.count), 32'd0);
        check_eq("rst.out_valid", 32'(iq.out_valid), 32'd0);
        check_eq("rst.in0_ready", 32'(iq.in0_ready), 32'd1);
        check_eq("rst.in1_ready_lo", 32'(iq.in1_ready), 32'd0);
        iq.in0_valid = 1'b1;
        #1;
        check_eq("rst.in1_ready_hi", 32'(iq.in1_ready), 32'd1);
        iq.in0_valid = 1'b0;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Dual push to full, then a blocked push while full with a pop, then drain.
        cycle("full1", 1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        cycle("full2", 1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
        cycle("full_hold", 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
        check_eq("full.model_size", 32'(model_q.size()), 32'd4);
        cycle("full_nobypass", 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
        for (int k = 0; k < 3; k++) cycle("drain", 1'b0, '0, 1'b0, '0, 1'b1);
        cycle("drained", 1'b0, '0, 1'b0, '0, 1'b1);

        // Lane 1 alone never enqueues; at count 3 only lane 0 fits.
        cycle("lane1_only", 1'b0, '0, 1'b1, 8'h55, 1'b0);
        cycle("lane1_only_chk", 1'b0, '0, 1'b0, '0, 1'b0);
        cycle("to3a", 1'b1, 8'h01, 1'b1, 8'h02, 1'b0);
        cycle("to3b", 1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
        cycle("at3_dual", 1'b1, 8'h04, 1'b1, 8'h05, 1'b0);
        for (int k = 0; k < 5; k++) cycle("gate_drain", 1'b0, '0, 1'b0, '0, 1'b1);

        // Push and pop together at count 2.
        cycle("pp_fill", 1'b1, 8'h60, 1'b1, 8'h61, 1'b0);
        cycle("pp_both", 1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
        for (int k = 0; k < 4; k++) cycle("pp_drain", 1'b0, '0, 1'b0, '0, 1'b1);

        // Sustained single push/pop wraps both pointers several times.
        for (int k = 0; k < 3*DEPTH; k++)
            cycle("wrap", 1'b1, WIDTH'(k+1), 1'b0, '0, 1'b1);
        cycle("wrap_tail", 1'b0, '0, 1'b0, '0, 1'b1);

        // Reset asserted between edges with three entries queued.
        cycle("r3a", 1'b1, 8'hA1, 1'b1, 8'hA2, 1'b0);
        cycle("r3b", 1'b1, 8'hA3, 1'b0, 8'h00, 1'b0);
        check_eq("r3.model_size", 32'(model_q.size()), 32'd3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_eq("midrst.count",     32'(iq.count), 32'd0);
        check_eq("midrst.out_valid", 32'(iq.out_valid), 32'd0);
        check_eq("midrst.in0_ready", 32'(iq.in0_ready), 32'd1);
        model_q.delete();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cycle("post_rst_push", 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
        cycle("post_rst_head", 1'b0, '0, 1'b0, '0, 1'b1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++)
            cycle("rand", 1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
                  1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 2) != 0));
        idle_cycles("final", 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
